// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button conditioner bank.
// Default thresholds assume a 50 MHz system clock.
package debounce_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_COUNT_PRESS   = 50000;     // 1 ms of stable low
    localparam int DEF_COUNT_RELEASE = 501;       // ~10 us of stable high
    localparam int DEF_LONG_PRESS    = 5000000;   // 100 ms hold
    localparam int DEF_REPEAT_EN     = 0;
    localparam int DEF_REPEAT_CYC    = 1000000;   // 20 ms repeat period

    // Debounced level of one channel
    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } chState_t;

    // Bits needed to hold any value in 0..maxVal
    function automatic int calcWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchroniser, press/release debounce FSM,
// hold counter with long-press pulse and optional auto-repeat.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int COUNT_PRESS   = DEF_COUNT_PRESS,
    parameter int COUNT_RELEASE = DEF_COUNT_RELEASE,
    parameter int LONG_PRESS    = DEF_LONG_PRESS,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_CYC    = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int CNT_W  = calcWidth(maxOf(COUNT_PRESS, COUNT_RELEASE));
    localparam int HOLD_W = calcWidth(LONG_PRESS);

    localparam logic [CNT_W-1:0]  PRESS_LAST   = CNT_W'(COUNT_PRESS - 1);
    localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'(COUNT_RELEASE - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST    = HOLD_W'(LONG_PRESS - 1);
    localparam logic [HOLD_W-1:0] LONG_MAX     = HOLD_W'(LONG_PRESS);

    logic              r_sync1;
    logic              r_sync2;
    chState_t          r_state;
    chState_t          w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_nextCnt;
    logic [HOLD_W-1:0] r_hold;
    logic              w_target;
    logic              w_pressEvt;
    logic              w_releaseEvt;
    logic              w_holdSat;
    logic              w_longEvt;
    logic              w_repeatEvt;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    // Bring the asynchronous pin into the clock domain; idle level is high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The pin is active-low, so the level we are heading towards is its inverse
    assign w_target = ~r_sync2;

    // Debounce state and stability counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Count consecutive cycles of disagreement and flip the level at threshold
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = '0;
        w_pressEvt   = 1'b0;
        w_releaseEvt = 1'b0;
        unique case (r_state)
            RELEASED: begin
                if (w_target) begin
                    if (r_cnt == PRESS_LAST) begin
                        w_nextState = PRESSED;
                        w_pressEvt  = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            PRESSED: begin
                if (!w_target) begin
                    if (r_cnt == RELEASE_LAST) begin
                        w_nextState  = RELEASED;
                        w_releaseEvt = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_nextState = RELEASED;
            end
        endcase
    end

    assign w_holdSat = (r_hold == LONG_MAX);
    assign w_longEvt = (r_state == PRESSED) && !w_releaseEvt && (r_hold == LONG_LAST);

    // Measure how long the debounced level has been held, saturating at the long-press mark
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= '0;
        end else if ((r_state == RELEASED) || w_releaseEvt) begin
            r_hold <= '0;
        end else if (!w_holdSat) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int REP_W = calcWidth(REPEAT_CYC);
            localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

            logic [REP_W-1:0] r_rep;

            // Free-running period counter that only runs once the hold has saturated
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_rep <= '0;
                end else if (!w_holdSat || w_releaseEvt || (r_rep == REP_LAST)) begin
                    r_rep <= '0;
                end else begin
                    r_rep <= r_rep + REP_W'(1);
                end
            end

            assign w_repeatEvt = w_holdSat && !w_releaseEvt && (r_rep == REP_LAST);
        end else begin : g_noRepeat
            assign w_repeatEvt = 1'b0;
        end
    endgenerate

    // Register the one-cycle event pulses so they line up with the level change
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_press   <= w_pressEvt | w_repeatEvt;
            r_release <= w_releaseEvt;
            r_long    <= w_longEvt;
        end
    end

    assign o_level   = (r_state == PRESSED);
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: one independent debounce_ch per
// active-low board button, outputs gathered into per-function buses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int COUNT_PRESS   = DEF_COUNT_PRESS,
    parameter int COUNT_RELEASE = DEF_COUNT_RELEASE,
    parameter int LONG_PRESS    = DEF_LONG_PRESS,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_CYC    = DEF_REPEAT_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] boton_in,
    output logic [N_CH-1:0] boton_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    generate
        if ((N_CH < 1) || (COUNT_PRESS < 2) || (COUNT_RELEASE < 2) ||
            (LONG_PRESS < 2) || (REPEAT_CYC < 2) ||
            (COUNT_PRESS >= LONG_PRESS) || (COUNT_RELEASE >= LONG_PRESS) ||
            ((REPEAT_EN != 0) && (REPEAT_EN != 1))) begin : g_paramCheck
            $error("debounce_bank: illegal parameter combination");
        end
    endgenerate

    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
            debounce_ch #(
                .COUNT_PRESS  (COUNT_PRESS),
                .COUNT_RELEASE(COUNT_RELEASE),
                .LONG_PRESS   (LONG_PRESS),
                .REPEAT_EN    (REPEAT_EN),
                .REPEAT_CYC   (REPEAT_CYC)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .i_raw    (boton_in[ch]),
                .o_level  (boton_out[ch]),
                .o_press  (press_pulse[ch]),
                .o_release(release_pulse[ch]),
                .o_long   (long_pulse[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: two copies (auto-repeat off and on) see
// the same stimulus; every row is checked one cycle-step at a time.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] boton_in;

    logic [1:0] outA, pressA, relA, longA;
    logic [1:0] outB, pressB, relB, longB;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       rstN;
        logic [1:0] btn;
        logic [1:0] expOut;
        logic [1:0] expPress;
        logic [1:0] expRel;
        logic [1:0] expLong;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(2), .COUNT_PRESS(5), .COUNT_RELEASE(3),
        .LONG_PRESS(20), .REPEAT_EN(0), .REPEAT_CYC(8)
    ) dutA (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .boton_out(outA), .press_pulse(pressA),
        .release_pulse(relA), .long_pulse(longA)
    );

    debounce_bank #(
        .N_CH(2), .COUNT_PRESS(5), .COUNT_RELEASE(3),
        .LONG_PRESS(20), .REPEAT_EN(1), .REPEAT_CYC(8)
    ) dutB (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .boton_out(outB), .press_pulse(pressB),
        .release_pulse(relB), .long_pulse(longB)
    );

    // Drive one row of inputs, let one rising edge sample it, settle just after
    task automatic applyStimulus(input logic rstN, input logic [1:0] btn);
        reset    = rstN;
        boton_in = btn;
        @(posedge clk);
        #1;
    endtask

    // Compare both copies against the hand-computed row expectation
    task automatic checkOutput(input string name, input int row,
                               input logic [1:0] eOut, input logic [1:0] ePressA,
                               input logic [1:0] ePressB, input logic [1:0] eRel,
                               input logic [1:0] eLong);
        logic [7:0] gotA, expA, gotB, expB;
        gotA = {outA, pressA, relA, longA};
        expA = {eOut, ePressA, eRel, eLong};
        gotB = {outB, pressB, relB, longB};
        expB = {eOut, ePressB, eRel, eLong};
        checks++;
        if (gotA === expA) passes++;
        else $display("[TB] FAIL %s row %0d dutA out/press/rel/long got %b_%b_%b_%b expected %b_%b_%b_%b",
                      name, row, outA, pressA, relA, longA, eOut, ePressA, eRel, eLong);
        checks++;
        if (gotB === expB) passes++;
        else $display("[TB] FAIL %s row %0d dutB out/press/rel/long got %b_%b_%b_%b expected %b_%b_%b_%b",
                      name, row, outB, pressB, relB, longB, eOut, ePressB, eRel, eLong);
    endtask

    initial begin
        reset    = 1'b0;
        boton_in = 2'b11;

        // Reset held with ch0 pressed, then released: press after 2+5 edges
        vecs[0]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[10] = '{1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[11] = '{1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        // Reset while pressed: level drops with no release pulse
        vecs[12] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

        for (int r = 0; r < 16; r++) begin
            applyStimulus(vecs[r].rstN, vecs[r].btn);
            checkOutput("resetTable", r, vecs[r].expOut, vecs[r].expPress,
                        vecs[r].expPress, vecs[r].expRel, vecs[r].expLong);
        end

        // Bounce on ch0 (low 3, high 1, low 10), glitch high 2 then low, then real release
        for (int i = 0; i < 28; i++) begin
            logic b0;
            b0 = !((i <= 2) || (i >= 4 && i <= 13) || (i >= 16 && i <= 19));
            applyStimulus(1'b1, {1'b1, b0});
            checkOutput("bounceRelease", i,
                        (i >= 10 && i <= 23) ? 2'b01 : 2'b00,
                        (i == 10) ? 2'b01 : 2'b00,
                        (i == 10) ? 2'b01 : 2'b00,
                        (i == 24) ? 2'b01 : 2'b00,
                        2'b00);
        end

        // Long hold on ch0: long at press+20, repeats at long+8 and long+16 on dutB only
        for (int j = 0; j < 63; j++) begin
            applyStimulus(1'b1, {1'b1, (j <= 43) ? 1'b0 : 1'b1});
            checkOutput("longRepeat", j,
                        (j >= 6 && j <= 47) ? 2'b01 : 2'b00,
                        (j == 6) ? 2'b01 : 2'b00,
                        (j == 6 || j == 34 || j == 42) ? 2'b01 : 2'b00,
                        (j == 48) ? 2'b01 : 2'b00,
                        (j == 26) ? 2'b01 : 2'b00);
        end

        // Both channels pressed together, reset at hold count 10, re-press after reset
        for (int k = 0; k < 31; k++) begin
            applyStimulus((k >= 16 && k <= 18) ? 1'b0 : 1'b1, 2'b00);
            checkOutput("dualMidReset", k,
                        ((k >= 6 && k <= 15) || k >= 25) ? 2'b11 : 2'b00,
                        (k == 6 || k == 25) ? 2'b11 : 2'b00,
                        (k == 6 || k == 25) ? 2'b11 : 2'b00,
                        2'b00,
                        2'b00);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel push-button conditioner. Successor of the single-button anti-bounce block.
- Adds per-channel input synchroniser, independent press/release debounce thresholds, and one-cycle press/release event pulses.
- Adds long-press detection with optional auto-repeat.
- Sits between the board buttons (active-low, idle high) and the mode/state-machine logic, which consumes clean levels and pulses.

Parameters:
N_CH, 4, number of independent button channels
COUNT_PRESS, 50000, consecutive clk cycles of low (pressed) input required to assert a level
COUNT_RELEASE, 501, consecutive clk cycles of high (released) input required to deassert a level
LONG_PRESS, 5000000, clk cycles the debounced level must stay high before long_pulse fires
REPEAT_EN, 0, 1 = emit repeat pulses on press_pulse after a long press
REPEAT_CYC, 1000000, period of auto-repeat pulses once long press is reached

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
boton_in  in  N_CH  raw button pins, asynchronous, 0 = pressed
boton_out  out  N_CH  debounced level, 1 = pressed
press_pulse  out  N_CH  one-cycle pulse on debounced press (and on each auto-repeat)
release_pulse  out  N_CH  one-cycle pulse on debounced release
long_pulse  out  N_CH  one-cycle pulse when a hold reaches LONG_PRESS

Behaviour:
- Reset: reset and clk as already decided (synchronous, active-low; clock clk). While reset=0 at a clk edge:
  - sync flops load 1 (idle);
  - boton_out, all pulses and all counters load 0.
  - A button held through reset is reported as a normal press after debounce; no pulse is emitted during reset.
- Synchroniser: 2-flop chain per channel; s = second stage. Debounce logic uses s only.
- Debounce counter per channel, width $clog2(max(COUNT_PRESS, COUNT_RELEASE)+1):
  - Target = ~s. If target != boton_out, counter increments; otherwise it clears to 0.
  - Press: counter == COUNT_PRESS-1 and target == 1 -> next edge sets boton_out=1, clears counter, and asserts press_pulse for exactly that cycle.
  - Release: counter == COUNT_RELEASE-1 and target == 0 -> next edge clears boton_out, clears counter, and asserts release_pulse.
  - Latency: stable raw change to boton_out = 2 + threshold cycles.
  - Any glitch back to the current state before threshold restarts the count from 0.
- Hold counter per channel, width $clog2(LONG_PRESS+1):
  - Clears when boton_out=0. Increments while boton_out=1 and saturates at LONG_PRESS.
  - long_pulse asserts once, on the cycle the counter transitions LONG_PRESS-1 -> LONG_PRESS.
- Repeat (REPEAT_EN=1 only):
  - Repeat counter runs while the hold counter is saturated.
  - Every REPEAT_CYC cycles it re-asserts press_pulse for 1 cycle; the first repeat comes REPEAT_CYC cycles after long_pulse.
  - REPEAT_EN=0: repeat logic is absent and press_pulse fires once per press.
- Release during hold or repeat: the release_pulse cycle clears the hold and repeat counters. No further long or repeat pulses.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- press_pulse and release_pulse on the same channel are never high in the same cycle.
- Reset mid-count: all state returns to reset values at that edge, with no partial pulses.
- Parameter legality (elaboration check): all counts >= 2; COUNT_PRESS and COUNT_RELEASE < LONG_PRESS.

Decomposition:
- Shared constants file debounce_pkg: default thresholds for 50 MHz, and a clog2-based width helper.
- Sub-module debounce_ch: one channel (sync, debounce FSM with states RELEASED/PRESSED, hold/repeat counters).
- debounce_bank instantiates N_CH copies via generate and concatenates outputs.

Test Plan:
All scenarios use N_CH=2, COUNT_PRESS=5, COUNT_RELEASE=3, LONG_PRESS=20, REPEAT_CYC=8.
1. Reset hold with boton_in=2'b10, then release reset -> boton_out=2'b00 during reset; ch0 press_pulse at cycle 7 after reset release; boton_out[0]=1 thereafter.
2. ch0 bounce: low 3 cycles, high 1, low 10 -> no pulse during bounce; boton_out[0]=1 exactly 7 cycles after the final falling edge; single press_pulse.
3. Release: high for 5 cycles after a stable press -> boton_out[0]=0 at 5 cycles (2+3); one release_pulse; high 2 cycles then low gives no release.
4. Long press, REPEAT_EN=0: hold low 40 cycles -> long_pulse exactly 20 cycles after press_pulse, once only; no extra press_pulse.
5. Repeat, REPEAT_EN=1: hold 50 cycles -> press_pulse at press, then at long+8 and long+16; release -> release_pulse, repeats stop.
6. Independence plus mid-count reset: press ch0 and ch1 on the same edge -> simultaneous press_pulse=2'b11; assert reset at hold count 10 -> all outputs 0, no long_pulse.
